// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register: main register plus one skid entry; optional stats with PIPE_STAGE_STATS_EN.
// Latency: 1 cycle from in_valid&in_ready to out_valid when empty; sustains one transfer per cycle.
// Backpressure: in_ready is registered-only (~rst & ~skid_valid); the skid entry absorbs the in-flight word when out_ready drops.
module pipe_stage_skid #(
  parameter int                DATA_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              push;
  logic              pop;

  // Ready depends only on held state (and reset), never on out_ready.
  assign in_ready  = ~rst & ~skid_valid;
  assign push      = in_valid & in_ready;
  assign pop       = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = 2'(main_valid) + 2'(skid_valid);

  // Storage update: reset beats flush, flush beats push/pop; the skid entry always drains into main.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= BUBBLE_DATA;
      skid_data  <= BUBBLE_DATA;
    end else if (!main_valid) begin
      if (push) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end
    end else if (!skid_valid) begin
      if (push && pop) begin
        main_data <= in_data;
      end else if (push) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end else if (pop) begin
        main_valid <= 1'b0;
        main_data  <= BUBBLE_DATA;
      end
    end else if (pop) begin
      main_data  <= skid_data;
      skid_valid <= 1'b0;
      skid_data  <= BUBBLE_DATA;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  // Saturating counters: stalled output cycles and flushes that actually killed something.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && main_valid && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, hand-written stall sequence, random run against a queue model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: out_ready is driven directly from the table or randomly.
module tb_pipe_stage_skid;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif

  pipe_stage_skid #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs for one cycle plus the expected state right after that cycle's edge.
  typedef struct {
    logic              rst;
    logic              iv;
    logic [DATA_W-1:0] id;
    logic              fl;
    logic              ordy;
    logic              e_ov;
    logic [DATA_W-1:0] e_od;
    logic [1:0]        e_occ;
    logic              e_irdy;
    int                e_fc;   // expected flush_cnt, -1 = not checked
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic iv, input logic [DATA_W-1:0] id, input logic fl,
                     input logic ordy, input logic ov, input logic [DATA_W-1:0] od,
                     input logic [1:0] occ, input logic irdy, input int fc);
    vec_t v;
    v.rst = r; v.iv = iv; v.id = id; v.fl = fl; v.ordy = ordy;
    v.e_ov = ov; v.e_od = od; v.e_occ = occ; v.e_irdy = irdy; v.e_fc = fc;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model state for the random phase.
  logic [DATA_W-1:0] q[$];
  longint            m_stall;
  longint            m_flush;

  initial begin
    logic [DATA_W-1:0] held;
    logic [31:0]       s0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    s0 = '0;

    //    rst iv id          fl ordy | ov od       occ irdy fc
    add(1, 1, 64'hDEAD,  0, 0,   0, 64'h0,    0, 0, -1);
    add(1, 1, 64'hDEAD,  0, 0,   0, 64'h0,    0, 0, 0);
    add(0, 0, 64'hDEAD,  0, 0,   0, 64'h0,    0, 1, -1);
    add(0, 1, 64'h10,    0, 1,   1, 64'h10,   1, 1, -1);
    add(0, 1, 64'h11,    0, 1,   1, 64'h11,   1, 1, -1);
    add(0, 1, 64'h12,    0, 1,   1, 64'h12,   1, 1, -1);
    add(0, 0, 64'h0,     0, 1,   0, 64'h0,    0, 1, -1);
    add(0, 1, 64'hA1,    0, 0,   1, 64'hA1,   1, 1, -1);
    add(0, 1, 64'hA2,    0, 0,   1, 64'hA1,   2, 0, -1);
    add(0, 0, 64'h0,     0, 1,   1, 64'hA2,   1, 1, -1);
    add(0, 0, 64'h0,     0, 1,   0, 64'h0,    0, 1, -1);
    add(0, 1, 64'hB1,    0, 0,   1, 64'hB1,   1, 1, -1);
    add(0, 1, 64'hB2,    0, 0,   1, 64'hB1,   2, 0, 0);
    add(0, 1, 64'hB3,    1, 0,   0, 64'h0,    0, 1, 1);
    add(0, 0, 64'h0,     0, 1,   0, 64'h0,    0, 1, 1);
    add(0, 1, 64'hC1,    0, 0,   1, 64'hC1,   1, 1, -1);
    add(0, 1, 64'hC2,    1, 0,   0, 64'h0,    0, 0, 0);
    add(0, 0, 64'h0,     0, 0,   0, 64'h0,    0, 1, 0);
    add(0, 1, 64'hD1,    0, 1,   1, 64'hD1,   1, 1, -1);
    add(0, 1, 64'hD2,    1, 1,   0, 64'h0,    0, 1, 1);
    add(0, 0, 64'h0,     0, 1,   0, 64'h0,    0, 1, 1);
    // Reset-with-flush vector: rst must win, so patch rst on the C2 row.
    vecs[16].rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].id;
      flush = vecs[i].fl; out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      check($sformatf("vec%0d out_data", i),  out_data,         vecs[i].e_od);
      check($sformatf("vec%0d occupancy", i), 64'(occupancy),   64'(vecs[i].e_occ));
      check($sformatf("vec%0d in_ready", i),  64'(in_ready),    64'(vecs[i].e_irdy));
`ifdef PIPE_STAGE_STATS_EN
      if (vecs[i].e_fc >= 0)
        check($sformatf("vec%0d flush_cnt", i), 64'(flush_cnt), 64'(vecs[i].e_fc));
`endif
    end

    // Stall: one entry held for 5 cycles with out_ready low must stay stable.
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 64'hE1; out_ready = 1'b0;
    @(posedge clk); #1;
    check("stall capture", out_data, 64'hE1);
    held = out_data;
`ifdef PIPE_STAGE_STATS_EN
    s0 = stall_cnt;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d out_data", k), out_data, held);
    end
`ifdef PIPE_STAGE_STATS_EN
    check("stall_cnt", 64'(stall_cnt), 64'(s0) + 64'd5);
`endif
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall drain", 64'(out_valid), 64'd0);

    // Random phase against a queue-level model of the stage.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk);
    q.delete(); m_stall = 0; m_flush = 0;
    for (int c = 0; c < 400; c++) begin
      logic do_push, do_pop;
      @(negedge clk);
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_data   = {$urandom, $urandom};
      #1;
      check("rand in_ready", 64'(in_ready), 64'(!rst && q.size() < 2));
      @(posedge clk);
      do_push = in_valid && !rst && q.size() < 2;
      do_pop  = out_ready && q.size() > 0;
      if (rst) begin
        q.delete(); m_stall = 0; m_flush = 0;
      end else begin
        if (q.size() > 0 && !out_ready) m_stall++;
        if (flush) begin
          if (q.size() > 0) m_flush++;
          q.delete();
        end else begin
          if (do_pop) void'(q.pop_front());
          if (do_push) q.push_back(in_data);
        end
      end
      #1;
      check("rand out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("rand out_data", out_data, (q.size() > 0) ? q[0] : 64'h0);
      check("rand occupancy", 64'(occupancy), 64'(q.size()));
`ifdef PIPE_STAGE_STATS_EN
      check("rand stall_cnt", 64'(stall_cnt), 64'(m_stall));
      check("rand flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
